led_sequencer: RTL
==================

Name: led_sequencer

Overview:
- Output side of the Moore sequencer.
- Consumes the 2-bit mode produced by the button/state block and drives an LED bank with a timed pattern per mode.
- Pattern timing is taken from the shared 1 kHz tick_mf strobe.
- Restarts its pattern cleanly on every mode change.

Parameters:
N_LEDS, 4, number of LED outputs (>=2)
STEP_TICKS, 250, tick_mf pulses per pattern step (>=1; 250 = 250 ms)
PWM_BITS, 3, brightness resolution (used only with LED_PWM_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_mf  in  1  single-clk 1 kHz strobe
mode  in  2  requested pattern (00 OFF, 01 RUN, 10 BLINK, 11 PING), synchronous to clk
led  out  N_LEDS  registered LED drive
step  out  1  one-clk pulse on every pattern step

Behaviour:
- Reset (rst_n low, async): led=0, step=0, tick_cnt=0, pos=0, dir=up, blink=0, mode_q=00.
- Change detect:
  - chg = (mode != mode_q).
  - On a chg edge: mode_q<=mode, tick_cnt<=0, pos<=0, dir<=up, blink<=1, step<=0.
- Step timer (mode_q != OFF, no chg):
  - On tick_mf, tick_cnt increments.
  - When tick_mf and tick_cnt==STEP_TICKS-1: tick_cnt<=0, step<=1 for that clk, pattern advances.
  - Otherwise step<=0.
  - Cycles without tick_mf hold tick_cnt.
- In OFF: tick_cnt held 0, step=0, pos/dir/blink frozen.
- Simultaneous chg and step event: chg wins; no step pulse, no advance.
- Pattern advance per mode:
  - RUN: pos<=pos+1, wraps N_LEDS-1 -> 0.
  - BLINK: blink<=~blink.
  - PING: pos moves by dir. At pos==N_LEDS-1 with dir=up, dir flips and pos<=N_LEDS-2. At pos==0 with dir=down, dir flips and pos<=1. Endpoints are never repeated: sequence 0,1,2,3,2,1,0,1...
- LED decode (registered every clk from mode_q/pos/blink):
  - OFF: all 0.
  - RUN and PING: one-hot bit pos.
  - BLINK: all 1 if blink else all 0.
- Latency:
  - led reflects a new mode 2 clk after mode changes.
  - led reflects an advance 1 clk after the step pulse.
- Widths:
  - tick_cnt width = clog2(STEP_TICKS), minimum 1.
  - pos width = clog2(N_LEDS).
- mode glitch (changes and returns within 1 clk): treated as two changes; the pattern restarts.

Optional Feature:
- LED_PWM_EN defined:
  - Adds input brightness [PWM_BITS-1:0].
  - Adds a free-running PWM_BITS counter pwm_cnt on clk; reset value 0.
  - Each led bit = pattern bit AND (pwm_cnt < brightness), registered.
  - brightness=0 gives LEDs always off; duty = brightness/2^PWM_BITS.
  - The gated output adds no latency beyond the existing register stage.
- LED_PWM_EN undefined:
  - No brightness port, no pwm_cnt.
  - led = pattern, exactly as above.

Decomposition:
- Shared package seq_pkg holds:
  - Mode encodings MODE_OFF/MODE_RUN/MODE_BLINK/MODE_PING (2-bit), also used by the state-change block.
  - DIR_UP/DIR_DOWN.
- One natural sub-module: step_timer.
  - Inputs: clk, rst_n, tick_mf, clr, en.
  - Output: step pulse.
  - Parameter: STEP_TICKS.

Test Plan:
- Reset, then mode=00 for 2000 ticks -> led=0000 throughout, step never asserted.
- mode=01, STEP_TICKS=4 -> led=0001 2 clk after change; then 0010, 0100, 1000, 0001 each 1 clk after step; step pulses every 4th tick_mf.
- mode=11, N_LEDS=4, STEP_TICKS=1 -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010, with no repeated endpoint.
- mode=10, then switch to 01 on the same clk as a terminal tick -> no step pulse, led=0001, tick_cnt restarts from 0; BLINK before the switch shows 1111 then 0000 alternating per step.
- rst_n low mid-RUN at pos=2 -> led=0000 and step=0 immediately (async); after release with mode=01, led=0001 within 2 clk.
- LED_PWM_EN, PWM_BITS=3, brightness=2, mode=10 in blink-on phase -> led=1111 for 2 of every 8 clk; brightness=0 -> led=0000 always.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the Moore sequencer blocks.
//   - mode_e : 2-bit pattern/mode encoding, produced by the button/state
//              block and consumed by led_sequencer.
//   - dir_e  : travel direction of the PING pattern.
//   - cntWidth() : counter width helper that never returns less than 1 bit.
// No ports (package).
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PING  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // A terminal count of 1 still needs a 1-bit register to exist.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_sequencer_step_timer.sv
// ---------------------------------------------------------------------------
// step_timer
// Divides the shared 1 kHz tick_mf strobe down to one pattern step every
// STEP_TICKS strobes.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   tick_mf in  single-clk 1 kHz strobe
//   clr     in  restart the count from 0 (mode change); beats a step event
//   en      in  counting allowed (pattern not OFF); count sits at 0 otherwise
//   o_fire  out combinational: this clk's edge completes a step
//   step    out registered one-clk pulse, high the clk after o_fire
// Parameter: STEP_TICKS (>=1) tick_mf pulses per step.
// ---------------------------------------------------------------------------
module step_timer
  import seq_pkg::*;
#(
  parameter int STEP_TICKS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_mf,
  input  logic clr,
  input  logic en,
  output logic o_fire,
  output logic step
);

  localparam int CNT_W = cntWidth(STEP_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] r_tickCnt;

  // A clear on the same clk as the terminal tick suppresses the step.
  assign o_fire = en && !clr && tick_mf && (r_tickCnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tickCnt <= '0;
      step      <= 1'b0;
    end else begin
      step <= o_fire;
      if (clr || !en) begin
        r_tickCnt <= '0;
      end else if (tick_mf) begin
        r_tickCnt <= o_fire ? '0 : r_tickCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Output side of the Moore sequencer: turns the 2-bit mode into a timed LED
// pattern (OFF, RUN chase, BLINK all, PING bounce). The pattern restarts
// from its first position whenever the mode changes.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   tick_mf    in  single-clk 1 kHz strobe
//   mode       in  [1:0] requested pattern (see seq_pkg::mode_e)
//   brightness in  [PWM_BITS-1:0] duty = brightness/2^PWM_BITS
//                  (present only when LED_PWM_EN is defined)
//   led        out [N_LEDS-1:0] registered LED drive
//   step       out one-clk pulse on every pattern step
// Parameters: N_LEDS (>=2), STEP_TICKS (>=1), PWM_BITS (>=1).
// Configuration macro: LED_PWM_EN adds brightness gating via a free-running
// PWM counter; without it led is the plain pattern.
// Latency: new mode visible on led 2 clk after mode changes; a step advance
// is visible on led 1 clk after the step pulse.
// ---------------------------------------------------------------------------
module led_sequencer
  import seq_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int STEP_TICKS = 250,
  parameter int PWM_BITS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_mf,
  input  logic [1:0]        mode,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] brightness,
`endif
  output logic [N_LEDS-1:0] led,
  output logic              step
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

  if (N_LEDS < 2 || STEP_TICKS < 1 || PWM_BITS < 1) begin : g_paramCheck
    $error("led_sequencer: illegal parameter set");
  end

  mode_e             r_modeQ;
  logic [POS_W-1:0]  r_pos;
  dir_e              r_dir;
  logic              r_blink;
  logic              w_chg;
  logic              w_en;
  logic              w_fire;
  logic [N_LEDS-1:0] w_pattern;

  // A glitch that returns within one clk still registers as two changes.
  assign w_chg = (mode != r_modeQ);
  assign w_en  = (r_modeQ != MODE_OFF);

  step_timer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_stepTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_mf(tick_mf),
    .clr    (w_chg),
    .en     (w_en),
    .o_fire (w_fire),
    .step   (step)
  );

  // Pattern position state. PING reverses at each end without repeating the
  // endpoint, so the turn-around step simply moves one place the other way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_modeQ <= MODE_OFF;
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      r_blink <= 1'b0;
    end else if (w_chg) begin
      r_modeQ <= mode_e'(mode);
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      r_blink <= 1'b1;
    end else if (w_fire) begin
      case (r_modeQ)
        MODE_RUN: begin
          r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
        end
        MODE_BLINK: begin
          r_blink <= ~r_blink;
        end
        MODE_PING: begin
          if (r_dir == DIR_UP) begin
            if (r_pos == POS_LAST) begin
              r_dir <= DIR_DOWN;
              r_pos <= r_pos - POS_W'(1);
            end else begin
              r_pos <= r_pos + POS_W'(1);
            end
          end else begin
            if (r_pos == '0) begin
              r_dir <= DIR_UP;
              r_pos <= r_pos + POS_W'(1);
            end else begin
              r_pos <= r_pos - POS_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pattern decode from the registered mode and position.
  always_comb begin
    w_pattern = '0;
    case (r_modeQ)
      MODE_RUN, MODE_PING: w_pattern[r_pos] = 1'b1;
      MODE_BLINK:          w_pattern = {N_LEDS{r_blink}};
      default:             w_pattern = '0;
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic                w_pwmOn;

  assign w_pwmOn = (r_pwmCnt < brightness);

  // Brightness gating shares the single led register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwmCnt <= '0;
      led      <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
      led      <= w_pattern & {N_LEDS{w_pwmOn}};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= w_pattern;
    end
  end
`endif

endmodule
